z80_bus_initiator: RTL and testbench

- Cycle-level Z80 bus-master model. Drives the CPU side of the expansion-board interface: address, data, MREQ*/IORQ*/RD*/WR*.
- Executes one memory or I/O read/write per request. Honours WAIT*. Returns read data.
- Generates the port writes and memory accesses that the board's decode gates and configuration latches receive.
- Synthesisable; one clock = one T-state.

---
 rtl/z80_bus_initiator.sv | 193 +++++++++++++++++++
 tb/tb_z80_bus_initiator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_initiator.sv
// z80_bus_initiator: cycle-level Z80 bus master, one clock per T-state.
// Runs one memory or I/O read/write per accepted request, honours WAIT*,
// and returns read data with a one-cycle done pulse.
// Optional feature macro: WAIT_TIMEOUT_EN. When it is defined, a wait that
// lasts MAX_WAIT TW cycles is force-terminated and flagged with timeout.
module z80_bus_initiator #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic [1:0]  cmd,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        timeout,
    output logic [15:0] adr,
    output logic [7:0]  dout,
    output logic        dout_oe,
    input  logic [7:0]  din,
    output logic        mreq_b,
    output logic        iorq_b,
    output logic        rd_b,
    output logic        wr_b,
    input  logic        wait_b
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TA,
        S_TW,
        S_T3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cmd;
    logic [15:0] r_adr;
    logic [7:0]  r_dout;
    logic [7:0]  r_rdata;
    logic        r_done;
    logic        w_accept;
    logic        w_is_io;
    logic        w_is_wr;
    logic        w_force;

    if (MAX_WAIT == 0 || MAX_WAIT > 65535) begin : g_max_wait_check
        $error("z80_bus_initiator: MAX_WAIT must be in 1..65535");
    end

    assign w_accept = (r_state == S_IDLE) && req;
    assign w_is_io  = r_cmd[1];
    assign w_is_wr  = r_cmd[0];

    assign adr   = r_adr;
    assign dout  = r_dout;
    assign rdata = r_rdata;
    assign done  = r_done;

`ifdef WAIT_TIMEOUT_EN
    localparam logic [15:0] LP_MAX_WAIT = 16'(MAX_WAIT);

    logic [15:0] r_wait_cnt;
    logic        r_forced;
    logic        r_timeout;

    assign timeout = r_timeout;
    // Counter holds the number of TW cycles entered so far, including the current one.
    assign w_force = (r_state == S_TW) && !wait_b && (r_wait_cnt >= LP_MAX_WAIT);

    // Wait-state counter and forced-termination flag for the current transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_forced   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait_cnt <= '0;
                r_forced   <= 1'b0;
            end else begin
                if (w_next == S_TW) begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                end
                if (w_force) begin
                    r_forced <= 1'b1;
                end
            end
            r_timeout <= (r_state == S_T3) && r_forced;
        end
    end
`else
    assign timeout = 1'b0;
    assign w_force = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture, read-data latch and done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cmd   <= '0;
            r_adr   <= '0;
            r_dout  <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd <= cmd;
                r_adr <= addr;
                if (cmd[0]) begin
                    r_dout <= wdata;
                end
            end
            if ((r_state == S_T3) && !w_is_wr) begin
                r_rdata <= din;
            end
            r_done <= (r_state == S_T3);
        end
    end

    // Next-state logic and bus strobes decoded from the current T-state.
    always_comb begin
        w_next  = r_state;
        ready   = 1'b0;
        mreq_b  = 1'b1;
        iorq_b  = 1'b1;
        rd_b    = 1'b1;
        wr_b    = 1'b1;
        dout_oe = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    w_next = S_T1;
                end
            end
            S_T1: begin
                dout_oe = w_is_wr;
                if (!w_is_io) begin
                    mreq_b = 1'b0;
                    rd_b   = w_is_wr;
                end
                w_next = S_T2;
            end
            S_T2, S_TA, S_TW, S_T3: begin
                dout_oe = w_is_wr;
                mreq_b  = w_is_io;
                iorq_b  = !w_is_io;
                rd_b    = w_is_wr;
                wr_b    = !w_is_wr;
                case (r_state)
                    S_T2: begin
                        if (w_is_io) begin
                            w_next = S_TA;
                        end else if (!wait_b) begin
                            w_next = S_TW;
                        end else begin
                            w_next = S_T3;
                        end
                    end
                    S_TA: begin
                        w_next = wait_b ? S_T3 : S_TW;
                    end
                    S_TW: begin
                        if (wait_b || w_force) begin
                            w_next = S_T3;
                        end
                    end
                    default: begin
                        w_next = S_IDLE;
                    end
                endcase
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_z80_bus_initiator.sv
// Self-checking bench for z80_bus_initiator: directed and random transactions
// checked clock by clock against a T-state timeline computed from the bus rules.
module tb_z80_bus_initiator;

    localparam int unsigned MAXW = 4;
`ifdef WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  cmd = '0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  din = '0;
    logic        wait_b = 1'b1;
    logic        ready, done, timeout, dout_oe, mreq_b, iorq_b, rd_b, wr_b;
    logic [7:0]  rdata, dout;
    logic [15:0] adr;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_dout  = '0;
    logic [7:0]  m_rdata = '0;
    logic [15:0] m_adr   = '0;

    z80_bus_initiator #(.MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset), .req(req), .ready(ready), .cmd(cmd),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .timeout(timeout),
        .adr(adr), .dout(dout), .dout_oe(dout_oe), .din(din), .mreq_b(mreq_b),
        .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .wait_b(wait_b)
    );

    always #5 clock = ~clock;

    // Issue one transaction from an IDLE negedge; returns at the negedge of the done cycle.
    // nwait = number of consecutive wait_b=0 samples starting at the first sample point.
    task automatic run_txn(input logic [1:0] c, input logic [15:0] a, input logic [7:0] d,
                           input int unsigned nwait, input string tag);
        bit          is_io, is_wr, to;
        int unsigned s, tw, t3;
        logic [7:0]  din_t3;
        logic [3:0]  e_strb;
        logic [3:0]  e_ctl;
        is_io  = c[1];
        is_wr  = c[0];
        s      = is_io ? 3 : 2;
        to     = TO_EN && (nwait > MAXW);
        tw     = to ? MAXW : nwait;
        t3     = (is_io ? 4 : 3) + tw;
        din_t3 = '0;

        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_issue: got %b want 1", tag, ready);
        end
        req = 1'b1; cmd = c; addr = a; wdata = d;
        m_adr = a;
        if (is_wr) m_dout = d;

        for (int unsigned k = 1; k <= t3 + 1; k++) begin
            @(negedge clock);
            if (k <= t3) begin
                e_strb = {is_io ? 1'b1 : 1'b0,
                          (is_io && k >= 2) ? 1'b0 : 1'b1,
                          (!is_wr && (!is_io || k >= 2)) ? 1'b0 : 1'b1,
                          (is_wr && k >= 2) ? 1'b0 : 1'b1};
                e_ctl  = {1'b0, 1'b0, 1'b0, is_wr};
            end else begin
                e_strb = 4'b1111;
                e_ctl  = {1'b1, 1'b1, to, 1'b0};
                if (!is_wr) m_rdata = din_t3;
            end
            checks++;
            if ({mreq_b, iorq_b, rd_b, wr_b} !== e_strb) begin
                errors++;
                $display("FAIL %s strobes(mreq,iorq,rd,wr) k=%0d: got %b want %b", tag, k, {mreq_b, iorq_b, rd_b, wr_b}, e_strb);
            end
            checks++;
            if ({ready, done, timeout, dout_oe} !== e_ctl) begin
                errors++;
                $display("FAIL %s ctl(ready,done,timeout,oe) k=%0d: got %b want %b", tag, k, {ready, done, timeout, dout_oe}, e_ctl);
            end
            checks++;
            if (adr !== m_adr || dout !== m_dout) begin
                errors++;
                $display("FAIL %s adr/dout k=%0d: got %h/%h want %h/%h", tag, k, adr, dout, m_adr, m_dout);
            end
            checks++;
            if (rdata !== m_rdata) begin
                errors++;
                $display("FAIL %s rdata k=%0d: got %h want %h", tag, k, rdata, m_rdata);
            end
            if (k <= t3) begin
                req   = (k < t3) ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd   = 2'($urandom);
                addr  = 16'($urandom);
                wdata = 8'($urandom);
                din   = 8'($urandom);
                if (k == t3) din_t3 = din;
                if (k < s || k >= t3) wait_b = 1'($urandom_range(0, 1));
                else wait_b = (k < s + nwait) ? 1'b0 : 1'b1;
            end
        end
    endtask

    task automatic idle_cycle();
        req = 1'b0;
        @(negedge clock);
        checks++;
        if ({ready, done, mreq_b, iorq_b, rd_b, wr_b, dout_oe} !== 7'b1011110) begin
            errors++;
            $display("FAIL idle: got %b want 1011110", {ready, done, mreq_b, iorq_b, rd_b, wr_b, dout_oe});
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ready, done, timeout, dout_oe, mreq_b, iorq_b, rd_b, wr_b} !== 8'b10001111 ||
            adr !== 16'h0 || dout !== 8'h0 || rdata !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: got ctl=%b adr=%h dout=%h rdata=%h want 10001111/0000/00/00",
                     {ready, done, timeout, dout_oe, mreq_b, iorq_b, rd_b, wr_b}, adr, dout, rdata);
        end
        @(negedge clock);
        reset = 1'b0;
        m_dout = '0; m_rdata = '0; m_adr = '0;
        idle_cycle();
    endtask

    task automatic test_mem_write();
        run_txn(2'd1, 16'h4000, 8'hA5, 0, "mem_write");
        idle_cycle();
    endtask

    task automatic test_io_write();
        run_txn(2'd3, 16'h7FC4, 8'hC4, 0, "io_write");
        idle_cycle();
    endtask

    task automatic test_mem_read_wait();
        run_txn(2'd0, 16'h8123, 8'h00, 3, "mem_read_w3");
        idle_cycle();
        run_txn(2'd2, 16'h00FE, 8'h00, 2, "io_read_w2");
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_txn(2'd1, 16'h1111, 8'h11, 0, "b2b_w1");
        run_txn(2'd1, 16'h2222, 8'h22, 1, "b2b_w2");
        run_txn(2'd0, 16'h3333, 8'h00, 0, "b2b_r3");
        run_txn(2'd3, 16'h4444, 8'h44, 0, "b2b_w4");
        idle_cycle();
    endtask

    task automatic test_long_wait();
        run_txn(2'd2, 16'hBEEF, 8'h00, MAXW, "wait_eq_max");
        idle_cycle();
        run_txn(2'd2, 16'hCAFE, 8'h00, MAXW + 3, "wait_gt_max");
        idle_cycle();
        run_txn(2'd1, 16'hD00D, 8'h5C, 20, "wait_long_mem");
        idle_cycle();
    endtask

    task automatic test_reset_in_tw();
        req = 1'b1; cmd = 2'd1; addr = 16'h1234; wdata = 8'h3C; wait_b = 1'b0;
        @(negedge clock);
        req = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({dout_oe, wr_b, mreq_b} !== 3'b100) begin
            errors++;
            $display("FAIL reset_tw_pre: got %b want 100", {dout_oe, wr_b, mreq_b});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mreq_b, iorq_b, rd_b, wr_b, dout_oe, ready, done} !== 7'b1111010 || adr !== 16'h0 || dout !== 8'h0) begin
            errors++;
            $display("FAIL reset_tw_async: got %b adr=%h dout=%h want 1111010/0000/00",
                     {mreq_b, iorq_b, rd_b, wr_b, dout_oe, ready, done}, adr, dout);
        end
        @(negedge clock);
        reset = 1'b0; wait_b = 1'b1;
        m_dout = '0; m_rdata = '0; m_adr = '0;
        repeat (3) idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 6), "random");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_io_write();
        test_mem_read_wait();
        test_back_to_back();
        test_long_wait();
        test_reset_in_tw();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
